uart_rx_os16: RTL and testbench

//  UART receiver paired with the UART transmitter on the serial link: 8N1, LSB first, idle-high line.

---
 rtl/uart_rx_os16_if.sv | 30 +++
 rtl/uart_rx_os16.sv | 122 ++++++++++++
 tb/tb_uart_rx_os16.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os16_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os16_if
// Brief    : Serial line input and received-byte outputs of the UART receiver
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_os16_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  modport slave (
    input  rx,
    output rx_data,
    output rx_done,
    output rx_busy,
    output frame_err
  );

  modport master (
    output rx,
    input  rx_data,
    input  rx_done,
    input  rx_busy,
    input  frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os16
// Brief    : 8N1 UART receiver, 16x oversampled, mid-bit sampling, glitch/framing checks
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os16 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_os16_if.slave   bus
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [1:0]       sync;
  logic             rs;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [2:0]       state;
  logic [7:0]       data_q;
  logic             done_q;
  logic             ferr_q;

  assign rs   = sync[1];
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 2'b11;
      div_cnt  <= '0;
      tick_cnt <= 4'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      state    <= IDLE;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync   <= {sync[0], bus.rx};
      done_q <= 1'b0;
      ferr_q <= 1'b0;

      if (tick) begin
        div_cnt  <= '0;
        tick_cnt <= tick_cnt + 4'd1;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          // Restart the divider on the edge so every sample lands mid-bit.
          if (!rs) begin
            state    <= START;
            div_cnt  <= '0;
            tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (tick && (tick_cnt == 4'd7)) begin
            tick_cnt <= 4'd0;
            if (rs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end
        end
        DATA: begin
          if (tick && (tick_cnt == 4'd15)) begin
            shift[bit_idx] <= rs;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick && (tick_cnt == 4'd15)) begin
            if (rs) begin
              data_q <= shift;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              ferr_q <= 1'b1;
              state  <= BREAK;
            end
          end
        end
        BREAK: begin
          // A held-low line reports once, then waits for the line to recover.
          if (rs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy   = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os16
// Brief    : Scoreboard-driven bench for uart_rx_os16 at 32 clocks per bit
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_os16_if bus ();

  uart_rx_os16 #(
    .CLK_FREQ (3_200_000),
    .BAUD     (100_000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int         pass_cnt  = 0;
  int         total_cnt = 0;
  int         done_cnt  = 0;
  int         ferr_cnt  = 0;
  int         done_cyc  = 0;
  int         start_cyc = 0;
  logic       prev_done = 1'b0;

  // Output monitor: pops the scoreboard on every RxDone pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_done) begin
        done_cnt++;
        done_cyc = cyc;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_extra: got byte %h, expected no output", bus.rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.rx_data !== exp_b)
            $display("FAIL scoreboard_data: got %h expected %h", bus.rx_data, exp_b);
          else
            pass_cnt++;
        end
        total_cnt++;
        if (prev_done || bus.frame_err)
          $display("FAIL done_pulse_shape: prev_done=%b frame_err=%b expected 0/0", prev_done, bus.frame_err);
        else
          pass_cnt++;
      end
      if (bus.frame_err) ferr_cnt++;
    end
    prev_done = bus.rx_done;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int per, input logic stop_bit);
    bus.rx    = 1'b0;
    start_cyc = cyc;
    step(per);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      step(per);
    end
    bus.rx = stop_bit;
    step(per);
    bus.rx = 1'b1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    bus.rx = 1'b1;
    step(3);
    total_cnt++;
    if (bus.rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus.rx_data);
    else pass_cnt++;
    total_cnt++;
    if ({bus.rx_done, bus.rx_busy, bus.frame_err} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {bus.rx_done, bus.rx_busy, bus.frame_err});
    else pass_cnt++;
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_single();
    int d0, f0, lat;
    d0 = done_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 32, 1'b1);
    step(4);
    lat = done_cyc - start_cyc;
    total_cnt++;
    if (done_cnt !== d0 + 1) $display("FAIL single_done_count: got %0d expected %0d", done_cnt, d0 + 1);
    else pass_cnt++;
    total_cnt++;
    if (lat < 306 || lat > 308) $display("FAIL single_latency: got %0d expected 307 +/-1", lat);
    else pass_cnt++;
    total_cnt++;
    if (ferr_cnt !== f0) $display("FAIL single_ferr: got %0d expected %0d", ferr_cnt, f0);
    else pass_cnt++;
    total_cnt++;
    if (bus.rx_data !== 8'hA5) $display("FAIL single_hold: got %h expected a5", bus.rx_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [7:0] seq [3];
    seq = '{8'h00, 8'hFF, 8'h55};
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(seq[i]);
      send_byte(seq[i], 32, 1'b1);
    end
    step(4);
    total_cnt++;
    if (done_cnt !== d0 + 3) $display("FAIL b2b_done_count: got %0d expected %0d", done_cnt, d0 + 3);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL b2b_queue: got %0d pending expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int d0, f0, busy_cnt;
    d0 = done_cnt; f0 = ferr_cnt; busy_cnt = 0;
    bus.rx = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (bus.rx_busy) busy_cnt++;
    end
    bus.rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.rx_busy) busy_cnt++;
    end
    total_cnt++;
    if (busy_cnt < 1 || busy_cnt > 20) $display("FAIL glitch_busy_len: got %0d expected 1..20", busy_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({done_cnt, ferr_cnt, 1'b0, bus.rx_busy} !== {d0, f0, 2'b00})
      $display("FAIL glitch_silent: got done=%0d ferr=%0d busy=%b expected %0d %0d 0",
               done_cnt, ferr_cnt, bus.rx_busy, d0, f0);
    else pass_cnt++;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 32, 1'b1);
    step(4);
    total_cnt++;
    if (bus.rx_data !== 8'h3C) $display("FAIL glitch_next: got %h expected 3c", bus.rx_data);
    else pass_cnt++;
  endtask

  task automatic test_framing();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'h81, 32, 1'b0);
    bus.rx = 1'b0;
    step(500);
    total_cnt++;
    if (bus.rx_busy !== 1'b1) $display("FAIL break_busy: got %b expected 1", bus.rx_busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.rx_data !== 8'h3C) $display("FAIL break_data_hold: got %h expected 3c", bus.rx_data);
    else pass_cnt++;
    bus.rx = 1'b1;
    step(5);
    total_cnt++;
    if (bus.rx_busy !== 1'b0) $display("FAIL break_release: got %b expected 0", bus.rx_busy);
    else pass_cnt++;
    total_cnt++;
    if (ferr_cnt !== f0 + 1) $display("FAIL break_ferr_count: got %0d expected %0d", ferr_cnt, f0 + 1);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== d0) $display("FAIL break_no_done: got %0d expected %0d", done_cnt, d0);
    else pass_cnt++;
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 32, 1'b1);
    step(4);
    total_cnt++;
    if (bus.rx_data !== 8'h7E) $display("FAIL break_next: got %h expected 7e", bus.rx_data);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int d0, f0;
    logic [7:0] b;
    d0 = done_cnt; f0 = ferr_cnt;
    b = 8'hC3;
    bus.rx = 1'b0;
    step(32);
    for (int i = 0; i < 3; i++) begin
      bus.rx = b[i];
      step(32);
    end
    rst    = 1'b1;
    bus.rx = 1'b1;
    step(1);
    total_cnt++;
    if ({bus.rx_data, bus.rx_done, bus.rx_busy, bus.frame_err} !== 11'h000)
      $display("FAIL midreset_state: got data=%h flags=%b expected 00 000",
               bus.rx_data, {bus.rx_done, bus.rx_busy, bus.frame_err});
    else pass_cnt++;
    rst = 1'b0;
    step(400);
    total_cnt++;
    if ({done_cnt, ferr_cnt} !== {d0, f0})
      $display("FAIL midreset_no_pulse: got done=%0d ferr=%0d expected %0d %0d", done_cnt, ferr_cnt, d0, f0);
    else pass_cnt++;
    exp_q.push_back(8'h12);
    send_byte(8'h12, 32, 1'b1);
    step(4);
    total_cnt++;
    if (bus.rx_data !== 8'h12) $display("FAIL midreset_next: got %h expected 12", bus.rx_data);
    else pass_cnt++;
  endtask

  task automatic test_baud_tolerance();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h6D);
    send_byte(8'h6D, 31, 1'b1);
    step(8);
    exp_q.push_back(8'h6D);
    send_byte(8'h6D, 33, 1'b1);
    step(8);
    total_cnt++;
    if (done_cnt !== d0 + 2) $display("FAIL tol_done_count: got %0d expected %0d", done_cnt, d0 + 2);
    else pass_cnt++;
    total_cnt++;
    if (ferr_cnt !== f0) $display("FAIL tol_ferr: got %0d expected %0d", ferr_cnt, f0);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL tol_queue: got %0d pending expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_mid_reset();
    test_baud_tolerance();
    step(10);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
